// File: rtl/key_load_sequencer.sv
// key_load_sequencer
// Boot-time loader for the control-unit unlock key. The key arrives MS chunk
// first over a valid/ready handshake. It is committed to o_key_out in one step
// when the last beat is accepted. Until then the core is held in reset.
// The loader enforces write-once, an inter-beat timeout and a bounded retry
// count that ends in a sticky lockout. The key itself is never checked here.
//
// Optional build macro: KEY_LOAD_PARITY_EN
//   Adds the input i_chunk_parity, which carries even parity over
//   i_chunk_data. An accepted beat with bad parity is dropped and the
//   attempt fails.
//
// Ports
//   clk             system clock
//   rst             asynchronous active-high reset
//   i_load_start    pulse, starts a key load (from IDLE or ERROR)
//   i_chunk_data    key chunk, MS chunk first
//   i_chunk_valid   chunk valid
//   i_chunk_parity  even parity over i_chunk_data (KEY_LOAD_PARITY_EN only)
//   o_chunk_ready   chunk accepted this cycle when valid is also high
//   o_key_out       committed key (0 until a load completes)
//   o_key_loaded    full key committed
//   o_core_hold     holds the processor in reset while high
//   o_load_error    the last attempt failed
//   o_lockout       retries exhausted, sticky until rst
//   o_busy          load in progress
//
// State | meaning
//   IDLE    | waiting for the first load_start
//   LOAD    | accepting beats, inter-beat timeout running
//   DONE    | key committed, terminal until rst
//   ERROR   | attempt failed, a new load_start may retry
//   LOCKOUT | retries exhausted, terminal until rst
module key_load_sequencer #(
  parameter int KEY_WIDTH      = 28,
  parameter int CHUNK_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load_start,
  input  logic [CHUNK_WIDTH-1:0] i_chunk_data,
  input  logic                   i_chunk_valid,
`ifdef KEY_LOAD_PARITY_EN
  input  logic                   i_chunk_parity,
`endif
  output logic                   o_chunk_ready,
  output logic [KEY_WIDTH-1:0]   o_key_out,
  output logic                   o_key_loaded,
  output logic                   o_core_hold,
  output logic                   o_load_error,
  output logic                   o_lockout,
  output logic                   o_busy
);

  localparam int BEATS  = KEY_WIDTH / CHUNK_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);
  // The shadow holds only the beats before the last one. The last chunk
  // goes straight into the committed key. This assumes at least two beats.
  localparam int SHW    = KEY_WIDTH - CHUNK_WIDTH;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR,
    S_LOCKOUT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SHW-1:0]     r_shadow;
  logic [KEY_WIDTH-1:0] r_key;
  logic [BEAT_W-1:0]  r_beat;
  logic [TO_W-1:0]    r_to;
  logic [RTY_W-1:0]   r_retry;

  logic w_accept;
  logic w_par_bad;
  logic w_good_beat;
  logic w_timeout;
  logic w_fail;
  logic w_start;

  assign w_accept = (r_state == S_LOAD) && i_chunk_valid;

`ifdef KEY_LOAD_PARITY_EN
  assign w_par_bad = w_accept && (i_chunk_parity != (^i_chunk_data));
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_good_beat = w_accept && !w_par_bad;
  // An accepted beat always beats an expiring timeout.
  assign w_timeout   = (r_state == S_LOAD) && !i_chunk_valid && (r_to == TO_LAST);
  assign w_fail      = w_par_bad || w_timeout;
  assign w_start     = (w_next == S_LOAD) && (r_state != S_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_chunk_ready = 1'b0;
    o_busy        = 1'b0;
    o_key_loaded  = 1'b0;
    o_core_hold   = 1'b1;
    o_load_error  = 1'b0;
    o_lockout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_load_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_chunk_ready = 1'b1;
        o_busy        = 1'b1;
        if (w_fail) begin
          // ERROR is reached with retry counts 0..MAX_RETRY-1.
          // A failure while already at MAX_RETRY ends in lockout.
          w_next = (r_retry == RTY_MAX) ? S_LOCKOUT : S_ERROR;
        end else if (w_good_beat && (r_beat == LAST_BEAT)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_key_loaded = 1'b1;
        o_core_hold  = 1'b0;
      end
      S_ERROR: begin
        o_load_error = 1'b1;
        // ERROR only exists while retries remain, so a start is always honoured.
        if (i_load_start) w_next = S_LOAD;
      end
      S_LOCKOUT: begin
        o_load_error = 1'b1;
        o_lockout    = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_key    <= '0;
      r_beat   <= '0;
      r_to     <= '0;
      r_retry  <= '0;
    end else begin
      if (w_start) begin
        r_shadow <= '0;
        r_beat   <= '0;
        r_to     <= '0;
      end else if (r_state == S_LOAD) begin
        if (w_good_beat) begin
          r_beat <= r_beat + 1'b1;
          r_to   <= '0;
          if (r_beat == LAST_BEAT) begin
            r_key <= {r_shadow, i_chunk_data};
          end else begin
            r_shadow <= {r_shadow[SHW-CHUNK_WIDTH-1:0], i_chunk_data};
          end
        end else if (!w_accept) begin
          r_to <= r_to + 1'b1;
        end
      end
      if ((r_state == S_LOAD) && (w_next == S_ERROR)) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  // r_key is written only when DONE is entered, which makes the key write-once.
  assign o_key_out = r_key;

endmodule
